// File: rtl/gcd_result_fifo_if.sv
// Handshake bundle between the GCD result producer, the result FIFO and its consumer.
// The slave modport is the FIFO side; the master modport drives results and consumes them.
interface gcd_result_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic [WIDTH-1:0] deq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clear_ovf;

  modport master (
    output res_data, res_valid, deq_ready, clear_ovf,
    input  deq_data, deq_valid, count, overflow
  );

  modport slave (
    input  res_data, res_valid, deq_ready, clear_ovf,
    output deq_data, deq_valid, count, overflow
  );
endinterface

// File: rtl/gcd_result_fifo.sv
// Captures one entry per rising edge of the GCD core's out_valid and buffers it for a
// valid/ready consumer; never stalls the core, drops on overflow and raises a sticky flag.
module gcd_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  gcd_result_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] deq_data_q, deq_data_d;
  logic             deq_valid_q, deq_valid_d;
  logic             overflow_q, overflow_d;
  logic             prev_valid_q;

  logic enq, deq, full, enq_acc, drop;

  // A result is the rising edge of out_valid; the core holds the level until its next handshake.
  assign enq     = bus.res_valid & ~prev_valid_q;
  assign deq     = deq_valid_q & bus.deq_ready;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign enq_acc = enq & (~full | deq);
  assign drop    = enq & full & ~deq;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(enq_acc) - CNT_W'(deq);
    overflow_d  = overflow_q;
    if (enq_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (drop)               overflow_d = 1'b1;
    else if (bus.clear_ovf) overflow_d = 1'b0;
    // Registered head: take the incoming word when it lands exactly at the next read slot.
    if (enq_acc && (wr_ptr_q == rd_ptr_d)) deq_data_d = bus.res_data;
    else                                   deq_data_d = mem_q[rd_ptr_d];
    deq_valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      deq_data_q   <= '0;
      deq_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      prev_valid_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      deq_data_q   <= deq_data_d;
      deq_valid_q  <= deq_valid_d;
      overflow_q   <= overflow_d;
      prev_valid_q <= bus.res_valid;
    end
  end

  // Storage is not reset; only accepted entries are written.
  always_ff @(posedge clock) begin
    if (reset && enq_acc) mem_q[wr_ptr_q] <= bus.res_data;
  end

  assign bus.deq_data  = deq_data_q;
  assign bus.deq_valid = deq_valid_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_gcd_result_fifo.sv
// Directed bench for gcd_result_fifo: reset, single result, order/wrap, overflow,
// full with simultaneous enq/deq, and clear-versus-set of the overflow flag.
module tb_gcd_result_fifo;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;

  gcd_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  gcd_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [31:0] v);
    bus.res_data  = v;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    tick();
  endtask

  initial begin
    int fill4 [4];
    int exp5  [4];
    n_vec  = 0;
    n_miss = 0;
    reset         = 1'b0;
    bus.res_data  = '0;
    bus.res_valid = 1'b0;
    bus.deq_ready = 1'b0;
    bus.clear_ovf = 1'b0;

    // 1: reset held over two edges while res_valid toggles
    bus.res_data  = 32'd99;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.deq_valid), 32'd0);
    chk("rst_count", 32'(bus.count),     32'd0);
    chk("rst_ovf",   32'(bus.overflow),  32'd0);
    chk("rst_data",  bus.deq_data,       32'd0);

    // 2: one result held high for 5 cycles gives exactly one entry
    bus.res_data  = 32'd6;
    bus.res_valid = 1'b1;
    tick();
    chk("single_count0", 32'(bus.count),     32'd1);
    chk("single_valid",  32'(bus.deq_valid), 32'd1);
    chk("single_data",   bus.deq_data,       32'd6);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_hold", 32'(bus.count), 32'd1);
    end
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    bus.res_valid = 1'b0;
    chk("single_pop_count", 32'(bus.count),     32'd0);
    chk("single_pop_valid", 32'(bus.deq_valid), 32'd0);
    tick();

    // 3: pulses 1..10 with consumer always ready; pointers wrap
    bus.deq_ready = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      bus.res_data  = 32'(v);
      bus.res_valid = 1'b1;
      tick();
      chk("order_valid", 32'(bus.deq_valid), 32'd1);
      chk("order_data",  bus.deq_data,       32'(v));
      chk("order_count", 32'(bus.count),     32'd1);
      bus.res_valid = 1'b0;
      tick();
      chk("order_empty", 32'(bus.count), 32'd0);
    end
    bus.deq_ready = 1'b0;

    // 4: fill, overflow on the fifth, drain in order
    fill4 = '{3, 5, 7, 9};
    foreach (fill4[i]) pulse(32'(fill4[i]));
    chk("full_count",  32'(bus.count),    32'd4);
    chk("full_noovf",  32'(bus.overflow), 32'd0);
    pulse(32'd11);
    chk("ovf_count",   32'(bus.count),    32'd4);
    chk("ovf_flag",    32'(bus.overflow), 32'd1);
    chk("ovf_head",    bus.deq_data,      32'd3);
    bus.deq_ready = 1'b1;
    foreach (fill4[i]) begin
      chk("drain_valid", 32'(bus.deq_valid), 32'd1);
      chk("drain_data",  bus.deq_data,       32'(fill4[i]));
      tick();
    end
    bus.deq_ready = 1'b0;
    chk("drain_count", 32'(bus.count),     32'd0);
    chk("drain_valid0", 32'(bus.deq_valid), 32'd0);
    chk("drain_ovf",   32'(bus.overflow),  32'd1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    // 5: full FIFO, new result arrives together with a dequeue
    foreach (fill4[i]) pulse(32'(fill4[i]));
    chk("sim_pre_count", 32'(bus.count), 32'd4);
    bus.res_data  = 32'd13;
    bus.res_valid = 1'b1;
    bus.deq_ready = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("sim_count", 32'(bus.count),    32'd4);
    chk("sim_ovf",   32'(bus.overflow), 32'd0);
    exp5 = '{5, 7, 9, 13};
    foreach (exp5[i]) begin
      chk("sim_drain", bus.deq_data, 32'(exp5[i]));
      tick();
    end
    bus.deq_ready = 1'b0;
    chk("sim_empty", 32'(bus.count), 32'd0);

    // 6: a drop in the same cycle as clear_ovf keeps the flag set
    for (int v = 20; v < 24; v++) pulse(32'(v));
    pulse(32'd24);
    chk("cs_ovf_set", 32'(bus.overflow), 32'd1);
    bus.res_data  = 32'd25;
    bus.res_valid = 1'b1;
    bus.clear_ovf = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("cs_set_wins", 32'(bus.overflow), 32'd1);
    chk("cs_count",    32'(bus.count),    32'd4);
    tick();
    bus.clear_ovf = 1'b0;
    chk("cs_cleared",  32'(bus.overflow), 32'd0);
    bus.deq_ready = 1'b1;
    for (int v = 20; v < 24; v++) begin
      chk("cs_drain", bus.deq_data, 32'(v));
      tick();
    end
    bus.deq_ready = 1'b0;
    chk("cs_empty", 32'(bus.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
